// File: rtl/csa_pair_resolver.sv
`default_nettype none
// ============================================================================
// Module   : csa_pair_resolver
// Purpose  : Resolves the redundant sum/carry pair produced by the 8-operand
//            carry-save reduction tree into a single W-bit binary word using a
//            digit-serial carry-propagate adder. The tree's correction constant
//            CORR is removed, and results outside [0, 2^W) are flagged.
// Ports    : clk           rising-edge clock
//            rst           synchronous reset, active-high
//            in_valid      in_a/in_b valid
//            in_ready      pair can be accepted (IDLE only, low during rst)
//            in_a, in_b    carry-save vectors (W bits each)
//            out_valid     result valid
//            out_ready     consumer accepts the result
//            out_sum       (in_a + in_b - CORR) mod 2^W
//            out_range_err result R = in_a + in_b - CORR is < 0 or >= 2^W
//            busy          operation in progress (RUN or DONE)
// Revision : 1.0 - initial release
// ============================================================================
module csa_pair_resolver #(
   parameter int W     = 13,
   parameter int DIGIT = 4,
   parameter int CORR  = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sum,
   output logic         out_range_err,
   output logic         busy
);

   localparam int c_NDIG = (W + DIGIT - 1) / DIGIT;
   localparam int c_TOT  = c_NDIG * DIGIT;
   // Number of meaningful bits in the most significant digit (1..DIGIT).
   localparam int c_LAST = W - (c_NDIG - 1) * DIGIT;
   localparam int c_CW   = (c_NDIG > 1) ? $clog2(c_NDIG) : 1;

   // Adding k = (2^W - CORR) mod 2^W subtracts CORR while biasing the sum by
   // 2^W (for CORR != 0), so the final carry directly encodes the range.
   localparam logic [W-1:0]     c_K     = W'(0 - CORR);
   localparam logic [c_TOT-1:0] c_K_EXT = c_TOT'(c_K);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [c_TOT-1:0] a_q, a_d;
   logic [c_TOT-1:0] b_q, b_d;
   logic [c_TOT-1:0] k_q, k_d;
   logic [c_CW-1:0]  cnt_q, cnt_d;
   logic [1:0]       carry_q, carry_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   logic [DIGIT+1:0] w_t;
   logic [1:0]       w_cout;
   logic             w_last;
   logic             w_err;

   // Digit adder: operands plus 2-bit carry, result fits in DIGIT+2 bits.
   always_comb begin
      w_t = (DIGIT+2)'(a_q[DIGIT-1:0]) + (DIGIT+2)'(b_q[DIGIT-1:0])
          + (DIGIT+2)'(k_q[DIGIT-1:0]) + (DIGIT+2)'(carry_q);
   end

   assign w_last = (cnt_q == c_CW'(c_NDIG - 1));
   // In a partial top digit the carry out is taken at bit W, not at the
   // digit boundary; the zero padding above keeps the shift exact.
   assign w_cout = w_last ? 2'(w_t >> c_LAST) : w_t[DIGIT+1:DIGIT];
   // Final carry: with CORR=0 the sum is R itself, otherwise it is R + 2^W.
   assign w_err  = (CORR == 0) ? (carry_q != 2'd0) : (carry_q != 2'd1);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      valid_d = valid_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = c_TOT'(in_a);
               b_d     = c_TOT'(in_b);
               k_d     = c_K_EXT;
               cnt_d   = '0;
               carry_d = '0;
               sum_d   = '0;
               err_d   = 1'b0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Bits of the top digit beyond W shift out of the W-bit result.
            sum_d   = sum_q | (W'(w_t[DIGIT-1:0]) << (int'(cnt_q) * DIGIT));
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            k_d     = k_q >> DIGIT;
            carry_d = w_cout;
            cnt_d   = cnt_q + c_CW'(1);
            if (w_last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // First DONE cycle latches the flag; result is presented next.
            if (!valid_q) begin
               valid_d = 1'b1;
               err_d   = w_err;
            end else if (out_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         carry_q <= '0;
         sum_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign in_ready      = (state_q == S_IDLE) && !rst;
   assign out_valid     = valid_q;
   assign out_sum       = sum_q;
   assign out_range_err = err_q;
   assign busy          = (state_q == S_RUN) || (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_csa_pair_resolver.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_pair_resolver
// Purpose  : Scoreboard bench for csa_pair_resolver: directed cases on a
//            DIGIT=4 instance plus random streams on DIGIT=1 and DIGIT=13
//            (CORR=0) instances, checked against an integer model of R.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csa_pair_resolver;

   localparam int W     = 13;
   localparam int DIGIT = 4;
   localparam int CORR  = 4;
   localparam int NDIG  = (W + DIGIT - 1) / DIGIT;
   localparam int N_RND = 2000;
   localparam int N_ALT = 400;

   typedef struct {
      logic [W-1:0] s;
      logic         e;
      int           acc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_range_err;
   logic         busy;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   bit   rnd_mode = 1'b0;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   csa_pair_resolver #(.W(W), .DIGIT(DIGIT), .CORR(CORR)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_range_err(out_range_err), .busy(busy)
   );

   // Reference: plain integer arithmetic on R = a + b - corr.
   function automatic logic [W:0] ref_model(input int a, input int b, input int corr);
      int r;
      int m;
      int s;
      logic e;
      m = 1 << W;
      r = a + b - corr;
      s = ((r % m) + m) % m;
      e = (r < 0) || (r >= m);
      return {e, W'(s)};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      int t;
      logic [W:0] m;
      @(posedge clk);
      #1;
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!in_ready && t < 300);
      if (!in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", t);
         in_valid = 1'b0;
         return;
      end
      m = ref_model(int'(a), int'(b), CORR);
      q.push_back('{m[W-1:0], m[W], cyc + 1});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding", q.size());
         q.delete();
      end
   endtask

   // Monitor / scoreboard for the main instance.
   logic         pv = 1'b0;
   logic         pr = 1'b0;
   logic [W-1:0] ps = '0;
   logic         pe = 1'b0;
   always @(negedge clk) begin
      if (out_valid) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_valid: out_valid=1 with no pending result, sum=%0d", out_sum);
         end else begin
            if (!pv) check("latency", cyc - q[0].acc, NDIG + 1);
            if (pv && !pr) begin
               check("hold_sum", int'(out_sum), int'(ps));
               check("hold_err", int'(out_range_err), int'(pe));
            end
            if (out_ready) begin
               check("sum", int'(out_sum), int'(q[0].s));
               check("err", int'(out_range_err), int'(q[0].e));
               void'(q.pop_front());
            end
         end
      end
      pv = out_valid;
      pr = out_ready;
      ps = out_sum;
      pe = out_range_err;
   end

   always @(posedge clk) begin
      if (rnd_mode) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Two extra configurations run independent random streams.
   bit alt_done [2];

   for (genvar g = 0; g < 2; g++) begin : g_alt
      localparam int AD = (g == 0) ? 1 : 13;
      localparam int AC = (g == 0) ? 4 : 0;
      localparam int AN = (W + AD - 1) / AD;

      logic         a_rst;
      logic         a_iv;
      logic         a_ir;
      logic [W-1:0] a_ia;
      logic [W-1:0] a_ib;
      logic         a_ov;
      logic         a_ordy = 1'b0;
      logic [W-1:0] a_os;
      logic         a_oe;
      logic         a_busy;
      exp_t         aq[$];

      csa_pair_resolver #(.W(W), .DIGIT(AD), .CORR(AC)) u_alt (
         .clk(clk), .rst(a_rst), .in_valid(a_iv), .in_ready(a_ir),
         .in_a(a_ia), .in_b(a_ib), .out_valid(a_ov), .out_ready(a_ordy),
         .out_sum(a_os), .out_range_err(a_oe), .busy(a_busy)
      );

      always @(posedge clk) begin
         #1;
         a_ordy = ($urandom_range(0, 3) != 0);
      end

      logic apv = 1'b0;
      always @(negedge clk) begin
         if (a_ov) begin
            if (aq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL alt%0d_unexpected_valid: sum=%0d", g, a_os);
            end else begin
               if (!apv) check($sformatf("alt%0d_latency", g), cyc - aq[0].acc, AN + 1);
               if (a_ordy) begin
                  check($sformatf("alt%0d_sum", g), int'(a_os), int'(aq[0].s));
                  check($sformatf("alt%0d_err", g), int'(a_oe), int'(aq[0].e));
                  void'(aq.pop_front());
               end
            end
         end
         apv = a_ov;
      end

      initial begin
         int t;
         logic [W:0] m;
         alt_done[g] = 1'b0;
         a_rst = 1'b1;
         a_iv  = 1'b0;
         a_ia  = '0;
         a_ib  = '0;
         repeat (3) @(posedge clk);
         #1;
         a_rst = 1'b0;
         for (int n = 0; n < N_ALT; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            @(posedge clk);
            #1;
            a_ia = W'($urandom);
            a_ib = W'($urandom);
            a_iv = 1'b1;
            t = 0;
            do begin
               @(negedge clk);
               t++;
            end while (!a_ir && t < 300);
            if (!a_ir) begin
               n_tests++;
               n_fail++;
               $display("FAIL alt%0d_accept_timeout", g);
               a_iv = 1'b0;
               break;
            end
            m = ref_model(int'(a_ia), int'(a_ib), AC);
            aq.push_back('{m[W-1:0], m[W], cyc + 1});
            @(posedge clk);
            #1;
            a_iv = 1'b0;
         end
         t = 0;
         while (aq.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
         end
         if (aq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL alt%0d_drain_timeout: %0d outstanding", g, aq.size());
         end
         alt_done[g] = 1'b1;
      end
   end

   initial begin
      int t;
      int tot;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_a = '0;
      in_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("in_ready_during_rst", int'(in_ready), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_sum", int'(out_sum), 0);
      check("rst_out_err", int'(out_range_err), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_in_ready", int'(in_ready), 1);

      // Basic results, carry ripple, range boundaries on both sides.
      out_ready = 1'b1;
      send(13'd100, 13'd50);
      drain();
      send(13'd4095, 13'd5);
      send(13'd1, 13'd2);
      send(13'd8191, 13'd8191);
      send(13'd0, 13'd4);
      send(13'd0, 13'd3);
      send(13'd0, 13'd0);
      send(13'd4000, 13'd4195);
      send(13'd4000, 13'd4196);
      drain();

      // Backpressure: result held, new input ignored.
      out_ready = 1'b0;
      send(13'd1234, 13'd4321);
      t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("bp_valid_seen", int'(out_valid), 1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         in_a = W'($urandom);
         in_b = W'($urandom);
         @(negedge clk);
         check("bp_in_ready", int'(in_ready), 0);
         check("bp_out_valid", int'(out_valid), 1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_release_in_ready", int'(in_ready), 1);
      check("bp_release_out_valid", int'(out_valid), 0);
      send(13'd7, 13'd1);
      drain();

      // Reset during the second RUN cycle aborts the operation.
      send(13'd2000, 13'd3000);
      @(posedge clk);
      #1;
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      check("abort_in_ready_low", int'(in_ready), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_out_valid", int'(out_valid), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_in_ready", int'(in_ready), 1);
      repeat (8) @(negedge clk);
      send(13'd7, 13'd9);
      drain();

      // Random stream: tree-style pairs (sum of eight 10-bit words plus CORR,
      // split arbitrarily) mixed with unconstrained pairs.
      rnd_mode = 1'b1;
      for (int n = 0; n < N_RND; n++) begin
         if ($urandom_range(0, 1) == 1) begin
            tot = CORR;
            for (int j = 0; j < 8; j++) tot += int'($urandom_range(0, 1023));
            ra = W'($urandom_range(0, tot));
            rb = W'(tot - int'(ra));
         end else begin
            ra = W'($urandom);
            rb = W'($urandom);
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
         send(ra, rb);
      end
      drain();
      rnd_mode = 1'b0;

      t = 0;
      while (!(alt_done[0] && alt_done[1]) && t < 40000) begin
         @(negedge clk);
         t++;
      end
      if (!(alt_done[0] && alt_done[1])) begin
         n_tests++;
         n_fail++;
         $display("FAIL alt_streams_timeout: done flags %0d %0d", alt_done[0], alt_done[1]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
